// File: rtl/stdc_readout_sequencer.sv
// rtl/stdc_readout_sequencer.sv - Wishbone master that drains the STDC timestamp FIFO into a stream
module stdc_readout_sequencer #(
  parameter logic [31:0] g_addr_ctrl     = 32'h0,
  parameter logic [31:0] g_addr_status   = 32'h4,
  parameter logic [31:0] g_addr_data     = 32'h8,
  parameter int unsigned g_poll_interval = 16,
  parameter int unsigned g_timeout       = 255
) (
  input  logic        clk_sys_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic [1:0]  filter_i,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_stall_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        ts_valid_o,
  output logic [31:0] ts_data_o,
  input  logic        ts_ready_i,
  output logic        busy_o,
  output logic [31:0] evt_cnt_o,
  output logic        bus_err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_WAIT,
    S_STAT,
    S_DATA,
    S_PUSH,
    S_ADV
  } state_t;

  // Poll counter runs 0..g_poll_interval-1, timeout counter 0..g_timeout-1.
  localparam int unsigned c_poll_w = (g_poll_interval > 1) ? $clog2(g_poll_interval) : 1;
  localparam int unsigned c_to_w   = (g_timeout > 1) ? $clog2(g_timeout) : 1;
  localparam logic [c_poll_w-1:0] c_poll_last = c_poll_w'(g_poll_interval - 1);
  localparam logic [c_to_w-1:0]   c_to_last   = c_to_w'(g_timeout - 1);

  state_t              state_q;
  logic                act_q;
  logic [31:0]         wb_adr_q;
  logic [31:0]         wb_dat_q;
  logic [3:0]          wb_sel_q;
  logic                wb_we_q;
  logic                wb_cyc_q;
  logic                wb_stb_q;
  logic                ts_valid_q;
  logic [31:0]         ts_data_q;
  logic [31:0]         evt_cnt_q;
  logic                bus_err_q;
  logic [1:0]          shadow_q;
  logic [c_poll_w-1:0] poll_cnt_q;
  logic [c_to_w-1:0]   to_cnt_q;

  logic [31:0]         launch_adr;
  logic [31:0]         launch_dat;
  logic                launch_we;

  // Address, direction and write data of the bus cycle owned by the current state.
  always_comb begin
    launch_adr = g_addr_status;
    launch_dat = 32'h0;
    launch_we  = 1'b0;
    case (state_q)
      S_CFG: begin
        launch_adr = g_addr_ctrl;
        launch_dat = {27'h0, filter_i, 3'b000};
        launch_we  = 1'b1;
      end
      S_ADV: begin
        // Advance always uses the filter that was last programmed, not the live input.
        launch_adr = g_addr_ctrl;
        launch_dat = {27'h0, shadow_q, 1'b1, 2'b00};
        launch_we  = 1'b1;
      end
      S_DATA: begin
        launch_adr = g_addr_data;
      end
      default: ;
    endcase
  end

  // Sequencer FSM: owns the bus master, the timestamp stream register and the counters.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      act_q      <= 1'b0;
      wb_adr_q   <= 32'h0;
      wb_dat_q   <= 32'h0;
      wb_sel_q   <= 4'h0;
      wb_we_q    <= 1'b0;
      wb_cyc_q   <= 1'b0;
      wb_stb_q   <= 1'b0;
      ts_valid_q <= 1'b0;
      ts_data_q  <= 32'h0;
      evt_cnt_q  <= 32'h0;
      bus_err_q  <= 1'b0;
      shadow_q   <= 2'b00;
      poll_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable_i) begin
            state_q <= S_CFG;
          end
        end

        S_WAIT: begin
          if (!enable_i) begin
            state_q <= S_IDLE;
          end else if (filter_i != shadow_q) begin
            state_q <= S_CFG;
          end else if (poll_cnt_q == c_poll_last) begin
            // Start the STATUS read on the same edge so the poll period is interval + 2.
            state_q  <= S_STAT;
            act_q    <= 1'b1;
            wb_cyc_q <= 1'b1;
            wb_stb_q <= 1'b1;
            wb_sel_q <= 4'hF;
            wb_we_q  <= 1'b0;
            wb_adr_q <= g_addr_status;
            wb_dat_q <= 32'h0;
            to_cnt_q <= '0;
          end else begin
            poll_cnt_q <= poll_cnt_q + 1'b1;
          end
        end

        S_PUSH: begin
          if (ts_ready_i) begin
            ts_valid_q <= 1'b0;
            evt_cnt_q  <= evt_cnt_q + 32'h1;
            state_q    <= S_ADV;
          end
        end

        S_CFG, S_STAT, S_DATA, S_ADV: begin
          if (!act_q) begin
            act_q    <= 1'b1;
            wb_cyc_q <= 1'b1;
            wb_stb_q <= 1'b1;
            wb_sel_q <= 4'hF;
            wb_we_q  <= launch_we;
            wb_adr_q <= launch_adr;
            wb_dat_q <= launch_dat;
            to_cnt_q <= '0;
            if (state_q == S_CFG) begin
              shadow_q <= filter_i;
            end
          end else begin
            if (wb_stb_q && !wb_stall_i) begin
              wb_stb_q <= 1'b0;
            end
            if (wb_err_i || (!wb_ack_i && to_cnt_q == c_to_last)) begin
              // Error or abandoned cycle: no data is used, retry from STATUS after a poll delay.
              act_q      <= 1'b0;
              wb_cyc_q   <= 1'b0;
              wb_stb_q   <= 1'b0;
              wb_sel_q   <= 4'h0;
              wb_we_q    <= 1'b0;
              bus_err_q  <= 1'b1;
              poll_cnt_q <= '0;
              state_q    <= S_WAIT;
            end else if (wb_ack_i) begin
              act_q    <= 1'b0;
              wb_cyc_q <= 1'b0;
              wb_stb_q <= 1'b0;
              wb_sel_q <= 4'h0;
              wb_we_q  <= 1'b0;
              if (state_q == S_CFG) begin
                state_q <= enable_i ? S_STAT : S_IDLE;
              end else if (state_q == S_STAT) begin
                if (!enable_i) begin
                  state_q <= S_IDLE;
                end else if (wb_dat_i[0]) begin
                  poll_cnt_q <= '0;
                  state_q    <= S_WAIT;
                end else begin
                  state_q <= S_DATA;
                end
              end else if (state_q == S_DATA) begin
                // Once read, the event is always delivered and advanced, even if disabled.
                ts_data_q  <= wb_dat_i;
                ts_valid_q <= 1'b1;
                state_q    <= S_PUSH;
              end else begin
                state_q <= enable_i ? S_STAT : S_IDLE;
              end
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign wb_adr_o   = wb_adr_q;
  assign wb_dat_o   = wb_dat_q;
  assign wb_sel_o   = wb_sel_q;
  assign wb_we_o    = wb_we_q;
  assign wb_cyc_o   = wb_cyc_q;
  assign wb_stb_o   = wb_stb_q;
  assign ts_valid_o = ts_valid_q;
  assign ts_data_o  = ts_data_q;
  assign evt_cnt_o  = evt_cnt_q;
  assign bus_err_o  = bus_err_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: doc/stdc_readout_sequencer.md
Name: stdc_readout_sequencer

Overview:
Wishbone pipelined master that autonomously drains the STDC (simple TDC) timestamp FIFO, replacing host polling over VME.
- Programs the STDC edge filter, polls STATUS, reads TDC_DATA, hands each timestamp to a valid/ready stream, then writes the CTRL "next" bit to advance the FIFO.
- Sits between the STDC Wishbone slave and the node-core message-queue / CPU side.

Parameters:
g_addr_ctrl, 32'h0, byte address of STDC CTRL register (bit3 = rising-edge filter, bit2 = next/advance, bit4 = falling-edge filter)
g_addr_status, 32'h4, byte address of STDC STATUS register (bit0 = FIFO empty)
g_addr_data, 32'h8, byte address of STDC TDC_DATA register
g_poll_interval, 16, clk_sys_i cycles between STATUS polls while FIFO is empty (>=1)
g_timeout, 255, cycles without ack/err before a bus cycle is aborted

Ports:
clk_sys_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
enable_i  in  1  1 = run sequencer
filter_i  in  2  edge filter, [0] = rising (CTRL bit3), [1] = falling (CTRL bit4)
wb_adr_o  out  32  Wishbone address
wb_dat_o  out  32  write data
wb_dat_i  in  32  read data
wb_sel_o  out  4  byte select, always 4'hF when cyc
wb_we_o  out  1  write enable
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_stall_i  in  1  pipelined stall
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  error
ts_valid_o  out  1  timestamp valid
ts_data_o  out  32  TDC_DATA word; [31] = edge polarity, [30:0] = timestamp
ts_ready_i  in  1  consumer ready
busy_o  out  1  1 when state != IDLE
evt_cnt_o  out  32  timestamps delivered (wraps at 2^32)
bus_err_o  out  1  one-cycle pulse on wb_err_i or timeout

Behaviour:
- Reset: all outputs 0, wb_sel_o 0, evt_cnt_o 0, state IDLE, filter shadow 0. Async assertion immediately drops cyc/stb/valid.
- Bus cycle (single transfer):
  - cyc and stb rise together; stb held until a cycle with stall=0; cyc held until ack or err.
  - One transfer per cycle; cyc drops the cycle after ack/err.
  - Latency with zero-wait slave: 2 cycles from stb to next state.
  - Timeout counter starts at stb and clears on ack/err. If it reaches g_timeout: drop cyc/stb, pulse bus_err_o, go WAIT.
  - wb_err_i: pulse bus_err_o, go WAIT. Read data is discarded on error.
- States:
  - IDLE: enable_i=1 -> CFG.
  - CFG: write CTRL = {filter_i[1]<<4 | filter_i[0]<<3}; latch filter shadow. ack -> STAT.
  - WAIT: count g_poll_interval cycles -> STAT. If enable_i=0 -> IDLE. If filter_i != shadow -> CFG.
  - STAT: read STATUS. bit0=1 -> WAIT; bit0=0 -> DATA.
  - DATA: read TDC_DATA into ts_data_o register -> PUSH.
  - PUSH: ts_valid_o=1; hold data stable until ts_ready_i=1 (transfer on valid&ready). Then increment evt_cnt_o and go ADV.
  - ADV: write CTRL = filter bits | (1<<2). ack -> STAT immediately, with no poll delay, for back-to-back drain.
- ts_valid_o never deasserts without a transfer, except on reset.
- enable_i=0 mid-operation: the current bus cycle completes. If the state is DATA/PUSH/ADV, the event is still delivered and advanced, then IDLE; no event is lost or double-read. From CFG/STAT, go to IDLE after the ack.
- Filter change outside WAIT is applied at the next WAIT entry. A CTRL advance write always uses the shadow.
- Error in ADV: event already delivered. Retry path re-reads STATUS after WAIT; no duplicate ADV is issued.
- evt_cnt_o 32'hFFFFFFFF + 1 -> 0.
- busy_o is combinational from state.

Test Plan:
1. Reset, enable=1, filter=2'b01, zero-wait slave with FIFO empty -> first cycle is write 0x8 to g_addr_ctrl, then STATUS reads every 16+2 cycles; ts_valid_o stays 0.
2. Preload FIFO with 3 words 0x80000064, 0x000000C8, 0x8000012C, ts_ready=1 -> 3 stream transfers in order, 3 CTRL writes of 0x0C, evt_cnt_o=3, then polling resumes.
3. ts_ready held 0 for 50 cycles with one event -> ts_valid_o=1 and data stable for 50 cycles, no ADV write until the handshake, evt_cnt_o increments once.
4. Slave stalls 5 cycles then acks; separately, slave never acks -> stb held through the stall with one transfer; bus_err_o pulses once at cycle 255, cyc drops, polling resumes.
5. enable_i dropped during PUSH -> event delivered, ADV write issued, busy_o=0 afterwards; rst_n_i asserted mid-cycle -> cyc/valid 0 the same cycle.
6. filter_i changed to 2'b11 while in WAIT -> CTRL write 0x18 before the next STATUS read; subsequent ADV writes use 0x1C.
